// File: rtl/tlb_op_sequencer_if.sv
// Request/response bus between the CP0/exception stage (master) and the TLB op sequencer (slave).
interface tlb_op_sequencer_if #(
  parameter int IDX_W   = 4,
  parameter int ENTRY_W = 78
);
  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_code;
  logic               done;
  logic [26:0]        cp0_entryhi;
  logic [IDX_W-1:0]   cp0_index;
  logic [ENTRY_W-1:0] cp0_entry;
  logic               probe_miss;
  logic [IDX_W-1:0]   probe_index;
  logic [ENTRY_W-1:0] rd_entry;

  modport master (
    output op_valid, op_code, cp0_entryhi, cp0_index, cp0_entry,
    input  op_ready, done, probe_miss, probe_index, rd_entry
  );

  modport slave (
    input  op_valid, op_code, cp0_entryhi, cp0_index, cp0_entry,
    output op_ready, done, probe_miss, probe_index, rd_entry
  );
endinterface

// File: rtl/tlb_op_sequencer.sv
// Executes TLBP/TLBR/TLBWI/TLBWR against a single-port TLB array and owns the CP0 Random/Wired pair.
// Optional macro TLBP_EARLY_EXIT_EN: TLBP stops scanning at the first matching entry.
module tlb_op_sequencer #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES),
  parameter int ENTRY_W     = 78
) (
  input  logic               clk,
  input  logic               resetn,
  tlb_op_sequencer_if.slave  op_if,
  input  logic               wired_we,
  input  logic [IDX_W-1:0]   wired_wdata,
  output logic [IDX_W-1:0]   random_out,
  output logic [IDX_W-1:0]   tlb_idx,
  output logic               tlb_re,
  input  logic [ENTRY_W-1:0] tlb_rdata,
  output logic               tlb_we,
  output logic [ENTRY_W-1:0] tlb_wdata
);
  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TLB_ENTRIES);

  typedef enum logic [2:0] {IDLE, RD_WAIT, PROBE, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [26:0]        entryhi_q;
  logic [IDX_W-1:0]   index_q, random_q;
  logic [ENTRY_W-1:0] entry_q;
  logic [IDX_W-1:0]   random_r, wired_r;
  logic [CNT_W-1:0]   scan_cnt;
  logic               cmp_valid;
  logic [IDX_W-1:0]   cmp_idx;
  logic               found;
  logic [IDX_W-1:0]   found_idx;
  logic               probe_miss_r;
  logic [IDX_W-1:0]   probe_index_r;
  logic [ENTRY_W-1:0] rd_entry_r;
  logic               accept, hit_now, probe_stop, random_adv;

  assign accept = (state == IDLE) && op_if.op_valid;

  // Entry read last cycle is compared now: vpn2 must match, and asid too unless the entry is global.
  assign hit_now = cmp_valid
                && (tlb_rdata[ENTRY_W-1 -: 19] == entryhi_q[26:8])
                && (tlb_rdata[ENTRY_W-28] || (tlb_rdata[ENTRY_W-20 -: 8] == entryhi_q[7:0]));

`ifdef TLBP_EARLY_EXIT_EN
  assign probe_stop = (scan_cnt == CNT_END) || hit_now;
`else
  assign probe_stop = (scan_cnt == CNT_END);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    op_if.op_ready = 1'b0;
    op_if.done     = 1'b0;
    tlb_re         = 1'b0;
    tlb_we         = 1'b0;
    tlb_idx        = '0;
    tlb_wdata      = entry_q;
    case (state)
      IDLE: begin
        op_if.op_ready = 1'b1;
        if (op_if.op_valid) begin
          case (op_if.op_code)
            OP_TLBP: state_nxt = PROBE;
            OP_TLBR: begin
              tlb_re    = 1'b1;
              tlb_idx   = op_if.cp0_index;
              state_nxt = RD_WAIT;
            end
            default: state_nxt = WRITE;
          endcase
        end
      end
      RD_WAIT: state_nxt = DONE;
      PROBE: begin
        if (probe_stop) begin
          state_nxt = DONE;
        end else begin
          tlb_re  = 1'b1;
          tlb_idx = scan_cnt[IDX_W-1:0];
        end
      end
      WRITE: begin
        tlb_we    = 1'b1;
        tlb_idx   = (op_q == OP_TLBWR) ? random_q : index_q;
        state_nxt = DONE;
      end
      DONE: begin
        op_if.done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q          <= '0;
      entryhi_q     <= '0;
      index_q       <= '0;
      random_q      <= '0;
      entry_q       <= '0;
      scan_cnt      <= '0;
      cmp_valid     <= 1'b0;
      cmp_idx       <= '0;
      found         <= 1'b0;
      found_idx     <= '0;
      probe_miss_r  <= 1'b0;
      probe_index_r <= '0;
      rd_entry_r    <= '0;
    end else begin
      cmp_valid <= (state == PROBE) && tlb_re;
      cmp_idx   <= tlb_idx;
      if (accept) begin
        op_q      <= op_if.op_code;
        entryhi_q <= op_if.cp0_entryhi;
        index_q   <= op_if.cp0_index;
        entry_q   <= op_if.cp0_entry;
        random_q  <= random_r;
        scan_cnt  <= '0;
        found     <= 1'b0;
      end
      // Only the first hit is kept so the lowest matching index wins.
      if (state == PROBE) begin
        if (!probe_stop) scan_cnt <= scan_cnt + 1'b1;
        if (hit_now && !found) begin
          found     <= 1'b1;
          found_idx <= cmp_idx;
        end
        if (probe_stop) begin
          if (found || hit_now) begin
            probe_miss_r  <= 1'b0;
            probe_index_r <= found ? found_idx : cmp_idx;
          end else begin
            probe_miss_r  <= 1'b1;
          end
        end
      end
      if (state == RD_WAIT) rd_entry_r <= tlb_rdata;
    end
  end

  // Random counts down toward Wired and wraps to the top; with Wired at the top it simply holds there.
  assign random_adv = !((state == WRITE) && (op_q == OP_TLBWR));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_r <= IDX_MAX;
      wired_r  <= '0;
    end else if (wired_we) begin
      wired_r  <= wired_wdata;
      random_r <= IDX_MAX;
    end else if (random_adv) begin
      if (random_r <= wired_r) random_r <= IDX_MAX;
      else                     random_r <= random_r - 1'b1;
    end
  end

  assign random_out        = random_r;
  assign op_if.probe_miss  = probe_miss_r;
  assign op_if.probe_index = probe_index_r;
  assign op_if.rd_entry    = rd_entry_r;

endmodule
